// File: rtl/traffic_ctrl.sv
// Round-robin traffic-light controller: green/yellow/all-red sequencing per direction,
// pedestrian-request early truncation of green, and a flashing-yellow fault/night mode.
module traffic_ctrl #(
  parameter int unsigned N_DIR         = 2,
  parameter int unsigned GREEN_CYC     = 6,
  parameter int unsigned MIN_GREEN_CYC = 2,
  parameter int unsigned YELLOW_CYC    = 2,
  parameter int unsigned ALLRED_CYC    = 1,
  parameter int unsigned FLASH_HALF    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flash,
  input  logic [N_DIR-1:0]         ped_req,
  output logic [N_DIR-1:0]         r,
  output logic [N_DIR-1:0]         y,
  output logic [N_DIR-1:0]         g,
  output logic [$clog2(N_DIR)-1:0] active_dir,
  output logic [N_DIR-1:0]         ped_pend
);

  localparam int unsigned DW     = $clog2(N_DIR);
  localparam int unsigned Max1   = (GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC;
  localparam int unsigned Max2   = (ALLRED_CYC > FLASH_HALF) ? ALLRED_CYC : FLASH_HALF;
  localparam int unsigned MaxCyc = (Max1 > Max2) ? Max1 : Max2;
  localparam int unsigned TW     = $clog2(MaxCyc + 1);

  typedef enum logic [1:0] {StGreen, StYellow, StAllred, StFlash} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [DW-1:0]    dir_q, dir_d, next_dir;
  logic [N_DIR-1:0] ped_q, ped_d, dir_oh;
  logic             blink_q, blink_d;
  logic             enter_green, ped_other;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StGreen;
      timer_q <= '0;
      dir_q   <= '0;
      ped_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      ped_q   <= ped_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    for (int d = 0; d < N_DIR; d++) begin
      dir_oh[d] = (dir_q == DW'(d));
    end
  end

  assign next_dir  = (dir_q == DW'(N_DIR - 1)) ? '0 : dir_q + DW'(1);
  assign ped_other = |(ped_q & ~dir_oh);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    dir_d       = dir_q;
    blink_d     = blink_q;
    enter_green = 1'b0;

    if (flash) begin
      if (state_q != StFlash) begin
        state_d = StFlash;
        timer_d = '0;
        blink_d = 1'b0;
      end else if (en) begin
        if (timer_q == TW'(FLASH_HALF - 1)) begin
          timer_d = '0;
          blink_d = ~blink_q;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    end else if (state_q == StFlash) begin
      // Leave flash so that the first green goes to direction 0.
      timer_d = '0;
      blink_d = 1'b0;
      if (ALLRED_CYC == 0) begin
        state_d     = StGreen;
        dir_d       = '0;
        enter_green = 1'b1;
      end else begin
        state_d = StAllred;
        dir_d   = DW'(N_DIR - 1);
      end
    end else if (en) begin
      timer_d = timer_q + TW'(1);
      case (state_q)
        StGreen: begin
          if ((timer_q == TW'(GREEN_CYC - 1)) ||
              (ped_other && (timer_q >= TW'(MIN_GREEN_CYC - 1)))) begin
            state_d = StYellow;
            timer_d = '0;
          end
        end
        StYellow: begin
          if (timer_q == TW'(YELLOW_CYC - 1)) begin
            timer_d = '0;
            if (ALLRED_CYC == 0) begin
              state_d     = StGreen;
              dir_d       = next_dir;
              enter_green = 1'b1;
            end else begin
              state_d = StAllred;
            end
          end
        end
        StAllred: begin
          if (timer_q == TW'(ALLRED_CYC - 1)) begin
            state_d     = StGreen;
            timer_d     = '0;
            dir_d       = next_dir;
            enter_green = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Requests always latch; serving a direction clears its bit, and clear wins.
    ped_d = ped_q | ped_req;
    if (enter_green) begin
      for (int d = 0; d < N_DIR; d++) begin
        if (dir_d == DW'(d)) ped_d[d] = 1'b0;
      end
    end
  end

  always_comb begin
    r = '0;
    y = '0;
    g = '0;
    case (state_q)
      StGreen: begin
        g = dir_oh;
        r = ~dir_oh;
      end
      StYellow: begin
        y = dir_oh;
        r = ~dir_oh;
      end
      StAllred: r = '1;
      StFlash:  y = {N_DIR{~blink_q}};
      default:  r = '1;
    endcase
  end

  assign active_dir = dir_q;
  assign ped_pend   = ped_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Scoreboard bench: expected lamp/dir/pending values are queued as stimulus is driven
// and compared one cycle later, for a 3-direction controller and a no-all-red 2-direction one.
module tb_traffic_ctrl;

  localparam int KG  = 0;
  localparam int KY  = 1;
  localparam int KR  = 2;
  localparam int KF1 = 3;
  localparam int KF0 = 4;

  typedef struct {
    string      tag;
    logic [7:0] r;
    logic [7:0] y;
    logic [7:0] g;
    logic [2:0] dir;
    logic [7:0] pend;
    bit         cdir;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, en_a = 1'b1, flash_a = 1'b0;
  logic [2:0] ped_a = '0, r_a, y_a, g_a, pend_a;
  logic [1:0] dir_a;

  logic       rst_b = 1'b1, en_b = 1'b1, flash_b = 1'b0;
  logic [1:0] ped_b = '0, r_b, y_b, g_b, pend_b;
  logic [0:0] dir_b;

  traffic_ctrl #(.N_DIR(3)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .flash(flash_a), .ped_req(ped_a),
    .r(r_a), .y(y_a), .g(g_a), .active_dir(dir_a), .ped_pend(pend_a)
  );

  traffic_ctrl #(.N_DIR(2), .ALLRED_CYC(0)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .flash(flash_b), .ped_req(ped_b),
    .r(r_b), .y(y_b), .g(g_b), .active_dir(dir_b), .ped_pend(pend_b)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input string tag, input int n, input int k, input int d,
                              input logic [7:0] pend, input bit cdir);
    exp_t       e;
    logic [7:0] m, oh;
    m      = 8'((1 << n) - 1);
    oh     = 8'(1 << d);
    e.tag  = tag;
    e.r    = '0;
    e.y    = '0;
    e.g    = '0;
    e.dir  = 3'(d);
    e.pend = pend;
    e.cdir = cdir;
    case (k)
      KG:  begin e.g = oh; e.r = m & ~oh; end
      KY:  begin e.y = oh; e.r = m & ~oh; end
      KR:  e.r = m;
      KF1: e.y = m;
      default: ;
    endcase
    return e;
  endfunction

  // Inputs change on the falling edge; the queued entry describes the next rising edge.
  task automatic drive_a(input logic rv, input logic ev, input logic fv, input logic [2:0] pv,
                         input string tag, input int k, input int d, input logic [7:0] pend,
                         input bit cdir);
    @(negedge clk);
    rst_a = rv; en_a = ev; flash_a = fv; ped_a = pv;
    qa.push_back(mk(tag, 3, k, d, pend, cdir));
  endtask

  task automatic step_a(input string tag, input logic [2:0] pv, input int k, input int d,
                        input logic [7:0] pend);
    drive_a(1'b0, 1'b1, 1'b0, pv, tag, k, d, pend, 1'b1);
  endtask

  task automatic drive_b(input logic rv, input logic fv, input string tag, input int k,
                         input int d, input bit cdir);
    @(negedge clk);
    rst_b = rv; en_b = 1'b1; flash_b = fv; ped_b = '0;
    qb.push_back(mk(tag, 2, k, d, 8'h00, cdir));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check({e.tag, "/lamps"}, {5'b0, r_a, 5'b0, y_a, 5'b0, g_a}, {8'h0, e.r, e.y, e.g});
        check({e.tag, "/pend"}, {29'b0, pend_a}, {24'b0, e.pend});
        if (e.cdir) check({e.tag, "/dir"}, {30'b0, dir_a}, {29'b0, e.dir});
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check({e.tag, "/lamps"}, {6'b0, r_b, 6'b0, y_b, 6'b0, g_b}, {8'h0, e.r, e.y, e.g});
        if (e.cdir) check({e.tag, "/dir"}, {31'b0, dir_b}, {29'b0, e.dir});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 2 directions, no all-red: period 16 (6 G, 2 Y per direction).
    drive_b(1'b1, 1'b0, "b_rst", KG, 0, 1'b1);
    for (int c = 1; c < 40; c++) begin
      int p;
      p = c % 16;
      drive_b(1'b0, 1'b0, $sformatf("b_seq%0d", c),
              (p < 6) ? KG : (p < 8) ? KY : (p < 14) ? KG : KY, (p < 8) ? 0 : 1, 1'b1);
    end
    drive_b(1'b0, 1'b1, "b_fl40", KF1, 0, 1'b0);
    drive_b(1'b0, 1'b1, "b_fl41", KF1, 0, 1'b0);
    for (int c = 42; c < 48; c++) drive_b(1'b0, 1'b0, $sformatf("b_rel%0d", c), KG, 0, 1'b1);
    drive_b(1'b0, 1'b0, "b_rel48", KY, 0, 1'b1);
    @(negedge clk);
    rst_b = 1'b1;

    // 3 directions, one all-red cycle: period 9 per direction.
    drive_a(1'b1, 1'b1, 1'b0, 3'b000, "a_rst", KG, 0, 8'h00, 1'b1);
    for (int c = 1; c < 30; c++) begin
      int p;
      p = c % 9;
      step_a($sformatf("a_seq%0d", c), 3'b000, (p < 6) ? KG : (p < 8) ? KY : KR,
             (c / 9) % 3, 8'h00);
    end

    // Request from a waiting direction truncates green.
    drive_a(1'b1, 1'b1, 1'b0, 3'b000, "p_rst", KG, 0, 8'h00, 1'b1);
    step_a("p_c1", 3'b010, KG, 0, 8'h02);
    step_a("p_c2", 3'b000, KY, 0, 8'h02);
    step_a("p_c3", 3'b000, KY, 0, 8'h02);
    step_a("p_c4", 3'b000, KR, 0, 8'h02);
    step_a("p_c5", 3'b000, KG, 1, 8'h00);

    // Request for the green direction latches without truncating; served in turn.
    drive_a(1'b1, 1'b1, 1'b0, 3'b000, "q_rst", KG, 0, 8'h00, 1'b1);
    step_a("q_c1", 3'b001, KG, 0, 8'h01);
    for (int c = 2; c < 6; c++) step_a($sformatf("q_c%0d", c), 3'b000, KG, 0, 8'h01);
    step_a("q_c6", 3'b000, KY, 0, 8'h01);
    step_a("q_c7", 3'b000, KY, 0, 8'h01);
    step_a("q_c8", 3'b000, KR, 0, 8'h01);
    step_a("q_c9", 3'b000, KG, 1, 8'h01);
    step_a("q_c10", 3'b000, KG, 1, 8'h01);
    step_a("q_c11", 3'b000, KY, 1, 8'h01);
    step_a("q_c12", 3'b000, KY, 1, 8'h01);
    step_a("q_c13", 3'b000, KR, 1, 8'h01);
    step_a("q_c14", 3'b000, KG, 2, 8'h01);
    step_a("q_c15", 3'b000, KG, 2, 8'h01);
    step_a("q_c16", 3'b000, KY, 2, 8'h01);
    step_a("q_c17", 3'b000, KY, 2, 8'h01);
    step_a("q_c18", 3'b000, KR, 2, 8'h01);
    step_a("q_c19_clrwin", 3'b001, KG, 0, 8'h00);

    // en=0 freezes mid-green; requests still latch.
    drive_a(1'b1, 1'b1, 1'b0, 3'b000, "e_rst", KG, 0, 8'h00, 1'b1);
    step_a("e_c1", 3'b000, KG, 0, 8'h00);
    step_a("e_c2", 3'b000, KG, 0, 8'h00);
    for (int c = 3; c < 8; c++) begin
      drive_a(1'b0, 1'b0, 1'b0, (c == 5) ? 3'b001 : 3'b000, $sformatf("e_hold%0d", c), KG, 0,
              (c >= 5) ? 8'h01 : 8'h00, 1'b1);
    end
    for (int c = 8; c < 11; c++) step_a($sformatf("e_c%0d", c), 3'b000, KG, 0, 8'h01);
    step_a("e_c11", 3'b000, KY, 0, 8'h01);
    step_a("e_c12", 3'b000, KY, 0, 8'h01);
    step_a("e_c13", 3'b000, KR, 0, 8'h01);
    step_a("e_c14", 3'b000, KG, 1, 8'h01);

    // Flash from yellow (entry with en=0), blink every 4, release via all-red to dir 0.
    drive_a(1'b1, 1'b1, 1'b0, 3'b000, "f_rst", KG, 0, 8'h00, 1'b1);
    for (int c = 1; c < 6; c++) step_a($sformatf("f_c%0d", c), 3'b000, KG, 0, 8'h00);
    step_a("f_c6", 3'b000, KY, 0, 8'h00);
    drive_a(1'b0, 1'b0, 1'b1, 3'b000, "f_c7", KF1, 0, 8'h00, 1'b0);
    for (int c = 8; c < 19; c++) begin
      drive_a(1'b0, 1'b1, 1'b1, 3'b000, $sformatf("f_c%0d", c),
              (((c - 7) / 4) % 2 == 0) ? KF1 : KF0, 0, 8'h00, 1'b0);
    end
    drive_a(1'b0, 1'b1, 1'b0, 3'b000, "f_c19", KR, 0, 8'h00, 1'b0);
    step_a("f_c20", 3'b000, KG, 0, 8'h00);
    step_a("f_c21", 3'b000, KG, 0, 8'h00);

    // Reset during flash wins on that edge; flash re-entered on the next.
    drive_a(1'b1, 1'b1, 1'b0, 3'b000, "r_rst", KG, 0, 8'h00, 1'b1);
    drive_a(1'b0, 1'b1, 1'b1, 3'b000, "r_c1", KF1, 0, 8'h00, 1'b0);
    drive_a(1'b0, 1'b1, 1'b1, 3'b000, "r_c2", KF1, 0, 8'h00, 1'b0);
    drive_a(1'b1, 1'b1, 1'b1, 3'b111, "r_c3", KG, 0, 8'h00, 1'b1);
    for (int c = 4; c < 8; c++) begin
      drive_a(1'b0, 1'b1, 1'b1, 3'b000, $sformatf("r_c%0d", c), KF1, 0, 8'h00, 1'b0);
    end
    drive_a(1'b0, 1'b1, 1'b1, 3'b000, "r_c8", KF0, 0, 8'h00, 1'b0);
    drive_a(1'b0, 1'b1, 1'b0, 3'b000, "r_c9", KR, 0, 8'h00, 1'b0);
    step_a("r_c10", 3'b000, KG, 0, 8'h00);

    repeat (3) @(posedge clk);
    #2;
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
